// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
`default_nettype none

// ============================================================================
//  Module   : nibble_serial_adder_if
//  Brief    : Valid/ready operand input and result output channels
//  Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice reused NIB times.
`default_nettype none

// ============================================================================
//  Module   : nibble_serial_adder
//  Brief    : WIDTH-bit add (A+B+cin) or subtract (A-B), one nibble per clock
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  nibble_serial_adder_if.slave       bus
);

  localparam int c_nib = WIDTH / 4;
  localparam int c_kw  = (c_nib > 1) ? $clog2(c_nib) : 1;
  localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nib - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-5:0] r_res;
  logic             r_carry;
  logic [c_kw-1:0]  r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:0]       w_c;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_shift;
  logic             w_last;

  // Operand registers shift right each RUN cycle, so the active nibble is always [3:0].
  always_comb begin
    w_p = r_a[3:0] ^ r_b[3:0];
    w_g = r_a[3:0] & r_b[3:0];
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_s = w_p ^ w_c[3:0];
  end

  // New nibble enters at the top; after the last slice the full result is aligned.
  assign w_shift = {w_s, r_res};
  assign w_last  = (r_k == c_k_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_carry     <= 1'b0;
      r_k         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.sub ? ~bus.b : bus.b;
            r_carry    <= bus.sub ? 1'b1 : bus.cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_res   <= w_shift[WIDTH-1:4];
          r_carry <= w_c[4];
          r_k     <= r_k + 1'b1;
          if (w_last) begin
            r_k         <= '0;
            r_sum       <= w_shift;
            r_cout      <= w_c[4];
            // Last slice: w_c[3] is the carry into the MSB, w_c[4] the carry out of it.
            r_ovf       <= w_c[3] ^ w_c[4];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are multiples of 4, at least 8; NIB = WIDTH/4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A.
REQ-007 SHALL have port b, input, WIDTH bits: operand B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-009 SHALL have port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: the result.
REQ-013 SHALL have port cout, output, 1 bit: carry out of the MSB; for sub=1, cout=0 means a borrow occurred.
REQ-014 SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE when in_valid=1, latch a into A_reg and latch b into B_reg (or ~b when sub=1), set carry_reg to cin (or 1 when sub=1), clear the nibble index k to 0, and go to RUN.
REQ-017 SHALL, in RUN, use one internal 4-bit carry-lookahead slice each cycle to add nibble k of A_reg, nibble k of B_reg and carry_reg, write that nibble of the internal result, update carry_reg to the slice carry-out, and increment k.
REQ-018 SHALL, in the RUN cycle where k=NIB-1, go to DONE and load sum, cout and overflow from the internal result; overflow is the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 SHALL keep sum, cout and overflow at their previous values outside that load, so they are stable throughout DONE.
REQ-020 SHALL give a latency such that, if operands are accepted at the edge ending cycle T, out_valid=1 in cycle T+NIB+1 (T+5 for WIDTH=16).
REQ-021 SHALL, in DONE, hold out_valid=1 until out_ready=1, then return to IDLE at that edge.
REQ-022 SHALL NOT accept new operands in the same cycle that a result is delivered; throughput is one operation per NIB+2 cycles at best.
REQ-023 SHALL ignore in_valid, a, b, cin and sub outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-024 SHALL compute all arithmetic modulo 2^WIDTH, with no saturation.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, enter IDLE with out_valid=0, sum=0, cout=0, overflow=0, carry_reg=0 and k=0; in_ready=1 in the cycle after reset is released.
REQ-026 SHALL, if rst is asserted in RUN or DONE, abandon the operation with no result emitted; rst takes priority over every other event in the same cycle.

Verification (WIDTH=16)
REQ-027 SHALL cover: a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, overflow=0, out_valid exactly 5 cycles after acceptance.
REQ-028 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
REQ-029 SHALL cover: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, overflow=0 (cin ignored).
REQ-030 SHALL cover: out_ready held at 0 for 3 cycles in DONE -> out_valid, sum, cout and overflow stay constant and in_ready=0; out_ready=1 -> the next cycle is IDLE with in_ready=1.
REQ-031 SHALL cover: in_valid held at 1 with changing a and b during RUN -> the result reflects only the operands latched at acceptance.
REQ-032 SHALL cover: rst=1 for one cycle during the second RUN cycle -> the next cycle has out_valid=0, in_ready=1 and sum=0, and no result is ever emitted for that operation.
